voice_sequencer: RTL and testbench

Sequences a bank of `wave_gen` voice generators at the audio sample rate, then mixes their outputs into one codec sample. On each sample request it latches per-voice configuration and pulses `aud_req` to every enabled voice. It then waits for each enabled voice's `aud_done`, sums the signed outputs with saturation, and hands the result to the codec interface over a valid/ready handshake. It sits between the host configuration bus and the `wave_gen` instances, and owns their step and scale inputs.

---
 rtl/voice_sequencer_pkg.sv | 34 +++
 rtl/voice_sequencer_if.sv | 30 +++
 rtl/voice_sequencer_cfg_regs.sv | 66 ++++++
 rtl/voice_sequencer.sv | 155 +++++++++++++++
 tb/tb_voice_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/voice_sequencer_pkg.sv
// ==== synth_pkg: shared types, constants and saturation helper ====
// ==== rev 1.0                                                  ====
`default_nettype none

package synth_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic [1:0] CFG_SEL_STEP = 2'd0;
  localparam logic [1:0] CFG_SEL_PRIM = 2'd1;
  localparam logic [1:0] CFG_SEL_SEC  = 2'd2;
  localparam logic [1:0] CFG_SEL_EN   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_MIX   = 3'd3,
    ST_OUT   = 3'd4
  } vseq_state_t;

  function automatic logic [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'h7fff;
    end else if (v < -32'sd32768) begin
      return 16'h8000;
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/voice_sequencer_if.sv
// ==== voice_sequencer_if: host config, sample request and codec handshake ====
// ==== rev 1.0                                                             ====
`default_nettype none

interface voice_sequencer_if #(
  parameter int NUM_VOICES = 4
);
  localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic               cfg_we;
  logic [VOICE_W-1:0] cfg_voice;
  logic [1:0]         cfg_sel;
  logic [31:0]        cfg_data;
  logic               sample_req;
  logic [15:0]        mix_data;
  logic               mix_valid;
  logic               mix_ready;

  modport master (
    output cfg_we, cfg_voice, cfg_sel, cfg_data, sample_req, mix_ready,
    input  mix_data, mix_valid
  );

  modport slave (
    input  cfg_we, cfg_voice, cfg_sel, cfg_data, sample_req, mix_ready,
    output mix_data, mix_valid
  );
endinterface

`default_nettype wire

// File: rtl/voice_sequencer_cfg_regs.sv
// ==== voice_cfg_regs: per-voice shadow/active parameter banks ====
// ==== rev 1.0                                                 ====
`default_nettype none

module voice_cfg_regs
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int VOICE_W    = 2
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  input  wire logic                    we_i,
  input  wire logic [VOICE_W-1:0]      voice_i,
  input  wire logic [1:0]              sel_i,
  input  wire logic [31:0]             data_i,
  input  wire logic                    copy_i,
  output logic      [NUM_VOICES*32-1:0] step_o,
  output logic      [NUM_VOICES*32-1:0] prim_o,
  output logic      [NUM_VOICES*32-1:0] sec_o,
  output logic      [NUM_VOICES-1:0]    en_o
);

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    logic [31:0] sh_step_q, sh_prim_q, sh_sec_q;
    logic [31:0] act_step_q, act_prim_q, act_sec_q;
    logic        sh_en_q, act_en_q;

    // A write coinciding with the copy lands in shadow only; active takes the old shadow.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sh_step_q  <= '0;
        sh_prim_q  <= '0;
        sh_sec_q   <= '0;
        sh_en_q    <= 1'b0;
        act_step_q <= '0;
        act_prim_q <= '0;
        act_sec_q  <= '0;
        act_en_q   <= 1'b0;
      end else begin
        if (we_i && (voice_i == VOICE_W'(v))) begin
          case (sel_i)
            CFG_SEL_STEP: sh_step_q <= data_i;
            CFG_SEL_PRIM: sh_prim_q <= data_i;
            CFG_SEL_SEC:  sh_sec_q  <= data_i;
            default:      sh_en_q   <= data_i[0];
          endcase
        end
        if (copy_i) begin
          act_step_q <= sh_step_q;
          act_prim_q <= sh_prim_q;
          act_sec_q  <= sh_sec_q;
          act_en_q   <= sh_en_q;
        end
      end
    end

    assign step_o[v*32 +: 32] = act_step_q;
    assign prim_o[v*32 +: 32] = act_prim_q;
    assign sec_o[v*32 +: 32]  = act_sec_q;
    assign en_o[v]            = act_en_q;
  end

endmodule

`default_nettype wire

// File: rtl/voice_sequencer.sv
// ==== voice_sequencer: issues per-sample voice requests and mixes the results ====
// ==== rev 1.0                                                                 ====
`default_nettype none

module voice_sequencer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int MIX_SHIFT   = 2,
  parameter int TIMEOUT_CYC = 2048
) (
  input  wire logic                            clk,
  input  wire logic                            reset,
  voice_sequencer_if.slave                     bus,
  output logic      [NUM_VOICES-1:0]           gen_req,
  output logic      [NUM_VOICES*32-1:0]        gen_step,
  output logic      [NUM_VOICES*32-1:0]        gen_primscale,
  output logic      [NUM_VOICES*32-1:0]        gen_secscale,
  input  wire logic [NUM_VOICES*SAMPLE_W-1:0]  gen_data,
  input  wire logic [NUM_VOICES-1:0]           gen_done,
  output logic                                 busy,
  output logic                                 timeout_err,
  output logic                                 overrun_err
);

  localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SUM_W   = SAMPLE_W + ((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 0);
  localparam int CNT_W   = $clog2(TIMEOUT_CYC + 1);

  vseq_state_t             state_q, state_d;
  logic [NUM_VOICES-1:0]   en_mask_q, en_mask_d;
  logic [NUM_VOICES-1:0]   done_seen_q, done_seen_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]     mix_q, mix_d;
  logic                    timeout_q, timeout_d;
  logic                    overrun_q, overrun_d;
  logic [NUM_VOICES-1:0]   active_en;
  logic                    copy;
  logic                    mix_valid;
  logic signed [SUM_W-1:0] sum, shifted;
  logic signed [31:0]      wide;

  assign copy = (state_q == ST_IDLE) && bus.sample_req;

  voice_cfg_regs #(
    .NUM_VOICES (NUM_VOICES),
    .VOICE_W    (VOICE_W)
  ) u_cfg (
    .clk     (clk),
    .reset   (reset),
    .we_i    (bus.cfg_we),
    .voice_i (bus.cfg_voice),
    .sel_i   (bus.cfg_sel),
    .data_i  (bus.cfg_data),
    .copy_i  (copy),
    .step_o  (gen_step),
    .prim_o  (gen_primscale),
    .sec_o   (gen_secscale),
    .en_o    (active_en)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      en_mask_q   <= '0;
      done_seen_q <= '0;
      cnt_q       <= '0;
      mix_q       <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_mask_q   <= en_mask_d;
      done_seen_q <= done_seen_d;
      cnt_q       <= cnt_d;
      mix_q       <= mix_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  // cnt_q == 0 marks the blanking cycle, when voices may still show last sample's done.
  always_comb begin
    state_d     = state_q;
    en_mask_d   = en_mask_q;
    done_seen_d = done_seen_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    overrun_d   = overrun_q | (bus.sample_req && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (bus.sample_req) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        en_mask_d   = active_en;
        done_seen_d = '0;
        cnt_d       = '0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q != '0) begin
          done_seen_d = done_seen_q | (gen_done & en_mask_q);
          if (&(done_seen_d | ~en_mask_q)) begin
            state_d = ST_MIX;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
            timeout_d = 1'b1;
            state_d   = ST_MIX;
          end
        end
      end
      ST_MIX: begin
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (bus.mix_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (done_seen_q[i]) begin
        sum = sum + SUM_W'($signed(gen_data[i*SAMPLE_W +: SAMPLE_W]));
      end
    end
    shifted = sum >>> MIX_SHIFT;
    wide    = 32'(shifted);
    mix_d   = (state_q == ST_MIX) ? sat16(wide) : mix_q;
  end

  always_comb begin
    gen_req   = '0;
    mix_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE:  busy      = 1'b0;
      ST_ISSUE: gen_req   = active_en;
      ST_OUT:   mix_valid = 1'b1;
      default:  busy      = 1'b1;
    endcase
  end

  assign bus.mix_valid = mix_valid;
  assign bus.mix_data  = mix_q;
  assign timeout_err   = timeout_q;
  assign overrun_err   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_voice_sequencer.sv
// ==== tb_voice_sequencer: directed and randomized sample runs against a reference model ====
// ==== rev 1.0                                                                           ====
`default_nettype none

module tb_voice_sequencer;

  localparam int NV = 4;
  localparam int T  = 2048;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_voice = '0;
  logic [1:0]    cfg_sel = '0;
  logic [31:0]   cfg_data = '0;
  logic          sample_req = 1'b0;
  logic          mix_ready = 1'b0;
  logic [NV*16-1:0] gen_data = '0;
  logic [NV-1:0]    gen_done = '0;

  logic [NV-1:0]    req_a, req_b;
  logic [NV*32-1:0] step_a, prim_a, sec_a, step_b, prim_b, sec_b;
  logic             busy_a, busy_b, to_a, to_b, ov_a, ov_b;

  voice_sequencer_if #(.NUM_VOICES(NV)) bus_a ();
  voice_sequencer_if #(.NUM_VOICES(NV)) bus_b ();

  assign bus_a.cfg_we = cfg_we;         assign bus_b.cfg_we = cfg_we;
  assign bus_a.cfg_voice = cfg_voice;   assign bus_b.cfg_voice = cfg_voice;
  assign bus_a.cfg_sel = cfg_sel;       assign bus_b.cfg_sel = cfg_sel;
  assign bus_a.cfg_data = cfg_data;     assign bus_b.cfg_data = cfg_data;
  assign bus_a.sample_req = sample_req; assign bus_b.sample_req = sample_req;
  assign bus_a.mix_ready = mix_ready;   assign bus_b.mix_ready = mix_ready;

  voice_sequencer #(.NUM_VOICES(NV), .MIX_SHIFT(2), .TIMEOUT_CYC(T)) u_dut_a (
    .clk (clk), .reset (reset), .bus (bus_a),
    .gen_req (req_a), .gen_step (step_a), .gen_primscale (prim_a), .gen_secscale (sec_a),
    .gen_data (gen_data), .gen_done (gen_done),
    .busy (busy_a), .timeout_err (to_a), .overrun_err (ov_a)
  );

  voice_sequencer #(.NUM_VOICES(NV), .MIX_SHIFT(0), .TIMEOUT_CYC(T)) u_dut_b (
    .clk (clk), .reset (reset), .bus (bus_b),
    .gen_req (req_b), .gen_step (step_b), .gen_primscale (prim_b), .gen_secscale (sec_b),
    .gen_data (gen_data), .gen_done (gen_done),
    .busy (busy_b), .timeout_err (to_b), .overrun_err (ov_b)
  );

  // Reference state: what the host has written and what each voice will do.
  logic [31:0] sh_step [NV], sh_prim [NV], sh_sec [NV];
  logic [31:0] act_step[NV], act_prim[NV], act_sec[NV];
  logic        sh_en   [NV];
  int          vdata   [NV];
  int          dly     [NV];
  bit          m_to, m_ov;
  int          checks, errors;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      sh_step[i] = '0; sh_prim[i] = '0; sh_sec[i] = '0; sh_en[i] = 1'b0;
      act_step[i] = '0; act_prim[i] = '0; act_sec[i] = '0;
    end
    m_to = 1'b0;
    m_ov = 1'b0;
  endtask

  task automatic write_cfg(input int v, input logic [1:0] sel, input logic [31:0] d);
    cfg_we = 1'b1; cfg_voice = 2'(v); cfg_sel = sel; cfg_data = d;
    case (sel)
      2'd0: sh_step[v] = d;
      2'd1: sh_prim[v] = d;
      2'd2: sh_sec[v]  = d;
      default: sh_en[v] = d[0];
    endcase
    tick();
    cfg_we = 1'b0;
  endtask

  function automatic logic [15:0] model_mix(input logic [NV-1:0] used, input int shift);
    longint s = 0;
    for (int i = 0; i < NV; i++) if (used[i]) s += longint'(vdata[i]);
    s = s >>> shift;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  function automatic int rand_s16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  task automatic run_sample(input int hold, input bit req_in_out, input bit req_with_ready,
                            input bit cfg_at_issue, input logic [31:0] new_step);
    logic [NV-1:0]    en, used;
    logic [NV*32-1:0] st, pr, se;
    logic [15:0]      exp_a, exp_b;
    bit               all_done;
    int               k, c;
    for (int i = 0; i < NV; i++) begin
      act_step[i] = sh_step[i]; act_prim[i] = sh_prim[i]; act_sec[i] = sh_sec[i];
      en[i] = sh_en[i];
      st[i*32 +: 32] = act_step[i]; pr[i*32 +: 32] = act_prim[i]; se[i*32 +: 32] = act_sec[i];
      gen_data[i*16 +: 16] = 16'(vdata[i]);
    end
    // A voice counts only if its done arrives by the last WAIT cycle before timeout.
    all_done = 1'b1; k = 3; used = '0;
    for (int i = 0; i < NV; i++) begin
      if (en[i]) begin
        if (dly[i] <= T + 2) begin
          used[i] = 1'b1;
          if (dly[i] > k) k = dly[i];
        end else begin
          all_done = 1'b0;
        end
      end
    end
    if (!all_done) k = T + 2;
    exp_a = model_mix(used, 2);
    exp_b = model_mix(used, 0);

    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    c = 1;
    if (cfg_at_issue) begin
      cfg_we = 1'b1; cfg_voice = 2'd1; cfg_sel = 2'd0; cfg_data = new_step;
      sh_step[1] = new_step;
    end
    gen_done = en;
    chk("gen_req_issue_a", req_a, en);
    chk("gen_req_issue_b", req_b, en);
    chk("gen_step", step_a, st);
    chk("gen_primscale", prim_a, pr);
    chk("gen_secscale", sec_a, se);
    chk("busy_issue", busy_a, 1);
    tick();
    c = 2;
    cfg_we = 1'b0;
    chk("gen_req_pulse", req_a, 0);
    chk("gen_step_hold", step_a, st);
    while (!bus_a.mix_valid && c < k + 20) begin
      tick();
      c++;
      for (int i = 0; i < NV; i++) gen_done[i] = en[i] && (dly[i] <= c);
    end
    m_to = m_to | !all_done;
    chk("valid_cycle", c, k + 2);
    chk("valid_b", bus_b.mix_valid, 1);
    chk("mix_data_a", bus_a.mix_data, exp_a);
    chk("mix_data_b", bus_b.mix_data, exp_b);
    chk("timeout_err", to_a, m_to);
    chk("overrun_err", ov_a, m_ov);
    for (int h = 0; h < hold; h++) begin
      if (req_in_out && h == 0) begin
        sample_req = 1'b1;
        m_ov = 1'b1;
      end
      tick();
      sample_req = 1'b0;
      chk("valid_held", bus_a.mix_valid, 1);
      chk("mix_data_stable", bus_a.mix_data, exp_a);
      chk("overrun_bp", ov_a, m_ov);
    end
    mix_ready = 1'b1;
    if (req_with_ready) begin
      sample_req = 1'b1;
      m_ov = 1'b1;
    end
    tick();
    mix_ready = 1'b0;
    sample_req = 1'b0;
    gen_done = '0;
    chk("valid_drop", bus_a.mix_valid, 0);
    chk("busy_idle", busy_a, 0);
    chk("overrun_a", ov_a, m_ov);
    chk("overrun_b", ov_b, m_ov);
    chk("timeout_b", to_b, m_to);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] old_step, nstep;
    checks = 0;
    errors = 0;
    model_reset();
    for (int i = 0; i < NV; i++) begin vdata[i] = 0; dly[i] = 3; end

    // Reset state
    tick(); tick();
    chk("rst_gen_req", {req_a, req_b}, 0);
    chk("rst_step", step_a, 0);
    chk("rst_prim_sec", {prim_a, sec_b}, 0);
    chk("rst_mix", {bus_a.mix_valid, bus_a.mix_data}, 0);
    chk("rst_flags", {busy_a, to_a, ov_a, busy_b}, 0);
    reset = 1'b1;
    tick();

    // Single voice nominal
    write_cfg(0, 2'd0, 32'h3d18aead);
    write_cfg(0, 2'd1, 32'h437f0000);
    write_cfg(0, 2'd2, 32'h3f800000);
    write_cfg(0, 2'd3, 32'h1);
    for (int i = 0; i < NV; i++) vdata[i] = rand_s16();
    dly[0] = 5;
    run_sample(2, 1'b0, 1'b0, 1'b0, '0);

    // Saturation, positive then negative full scale
    for (int i = 1; i < NV; i++) write_cfg(i, 2'd3, 32'h1);
    for (int i = 0; i < NV; i++) begin vdata[i] = 32767; dly[i] = 3 + i; end
    run_sample(0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < NV; i++) begin vdata[i] = -32768; dly[i] = 6 - i; end
    run_sample(1, 1'b0, 1'b0, 1'b0, '0);

    // Overrun under backpressure, plus request together with ready
    for (int i = 0; i < NV; i++) begin vdata[i] = rand_s16(); dly[i] = int'($urandom_range(3, 9)); end
    run_sample(4, 1'b1, 1'b1, 1'b0, '0);

    // Config write landing during ISSUE
    old_step = sh_step[1];
    nstep = $urandom;
    run_sample(0, 1'b0, 1'b0, 1'b1, nstep);
    chk("cfg_shadow_only", step_a[63:32], old_step);
    run_sample(0, 1'b0, 1'b0, 1'b0, '0);
    chk("cfg_new_active", step_a[63:32], nstep);

    // Randomized samples
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NV; i++) begin
        write_cfg(i, 2'(i % 3), $urandom);
        write_cfg(i, 2'd3, 32'($urandom_range(0, 1)));
        vdata[i] = rand_s16();
        dly[i] = int'($urandom_range(3, 12));
      end
      run_sample(int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, '0);
    end

    // Timeout: only voice 2 enabled and it never finishes
    for (int i = 0; i < NV; i++) write_cfg(i, 2'd3, (i == 2) ? 32'h1 : 32'h0);
    for (int i = 0; i < NV; i++) vdata[i] = rand_s16();
    dly[2] = 1 << 20;
    run_sample(0, 1'b0, 1'b0, 1'b0, '0);
    dly[2] = 4;
    run_sample(0, 1'b0, 1'b0, 1'b0, '0);

    // Asynchronous reset in the middle of WAIT
    write_cfg(2, 2'd3, 32'h1);
    dly[2] = 1 << 20;
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    chk("rst_wait_req", {req_a, req_b}, 0);
    chk("rst_wait_valid", {bus_a.mix_valid, bus_b.mix_valid}, 0);
    chk("rst_wait_busy", {busy_a, busy_b}, 0);
    chk("rst_wait_flags", {to_a, ov_a, bus_a.mix_data}, 0);
    tick(); tick();
    reset = 1'b1;
    model_reset();
    tick();
    for (int i = 0; i < NV; i++) vdata[i] = rand_s16();
    run_sample(0, 1'b0, 1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
